// File: rtl/posit_pkg.sv
// Shared posit definitions: regime-width function, stage-1 payload and NaR pattern.
package posit_pkg;

  localparam int unsigned POSIT_MAX_BITS = 64;

  // NaR is a lone MSB; narrower words use the top BITS bits of this constant.
  localparam logic [POSIT_MAX_BITS-1:0] POSIT_NAR_MSB = {1'b1, {(POSIT_MAX_BITS-1){1'b0}}};

  function automatic int unsigned posit_rw(input int unsigned bits);
    return int'($clog2(bits)) + 1;
  endfunction

  typedef struct packed {
    logic                      sign;
    logic                      zero;
    logic                      nar;
    logic [POSIT_MAX_BITS-1:0] magnitude;
  } posit_s1_t;

endpackage

// File: rtl/posit_regime_lzd.sv
// Leading-run detector: counts bits equal to the top body bit, scanning downward.
module posit_regime_lzd
  import posit_pkg::*;
#(
  parameter int unsigned BITS = 32
) (
  input  logic [BITS-2:0]               body,
  output logic                          b,
  output logic [posit_rw(BITS)-1:0]     run
);

  localparam int unsigned RW = posit_rw(BITS);

  logic done;

  always_comb begin
    b    = body[BITS-2];
    run  = '0;
    done = 1'b0;
    for (int unsigned i = 0; i < BITS - 1; i++) begin
      if (!done && (body[BITS-2-i] == b)) run = run + RW'(1);
      else                                done = 1'b1;
    end
  end

endmodule

// File: rtl/posit_unpack_pipe.sv
// Two-stage posit field decoder with valid/ready handshake on both sides.
// Optional out_scale port is enabled by defining POSIT_UNPACK_SCALE_EN.
module posit_unpack_pipe
  import posit_pkg::*;
#(
  parameter int unsigned BITS = 32,
  parameter int unsigned ES   = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [BITS-1:0]                      in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_sign,
  output logic                                 out_zero,
  output logic                                 out_nar,
  output logic signed [posit_rw(BITS)-1:0]     out_regime,
  output logic [((ES > 0) ? ES : 1)-1:0]       out_exp,
  output logic [BITS-1:0]                      out_frac
`ifdef POSIT_UNPACK_SCALE_EN
  ,
  output logic signed [posit_rw(BITS)+ES-1:0]  out_scale
`endif
);

  localparam int unsigned RW = posit_rw(BITS);
  localparam int unsigned EW = (ES > 0) ? ES : 1;

  logic                 s1_valid_q, s1_valid_d;
  posit_s1_t            s1_q, s1_d;
  logic                 out_valid_q, out_valid_d;
  logic                 sign_q, sign_d, zero_q, zero_d, nar_q, nar_d;
  logic signed [RW-1:0] regime_q, regime_d;
  logic [EW-1:0]        exp_q, exp_d;
  logic [BITS-1:0]      frac_q, frac_d;

  logic                 s2_adv;
  logic [BITS-1:0]      mag_v;
  logic [BITS-2:0]      body;
  logic [BITS-2:0]      rest;
  logic                 lzd_b;
  logic [RW-1:0]        run;
  logic signed [RW-1:0] regime_v;
  logic [EW-1:0]        exp_v;
  logic [BITS-1:0]      frac_v;
  logic                 special;
  logic [POSIT_MAX_BITS-1:0] unused_mag;

  assign unused_mag = s1_q.magnitude;

  always_comb begin
    s2_adv   = ~out_valid_q | out_ready;
    in_ready = ~s1_valid_q | s2_adv;
  end

  always_comb begin
    mag_v      = in_data[BITS-1] ? (~in_data + 1'b1) : in_data;
    s1_d       = s1_q;
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    if (in_ready && in_valid) begin
      s1_d.sign      = in_data[BITS-1];
      s1_d.zero      = (in_data == '0);
      s1_d.nar       = (in_data == POSIT_NAR_MSB[POSIT_MAX_BITS-1 -: BITS]);
      s1_d.magnitude = POSIT_MAX_BITS'(mag_v);
    end
  end

  assign body = s1_q.magnitude[BITS-2:0];

  posit_regime_lzd #(.BITS(BITS)) u_lzd (
    .body (body),
    .b    (lzd_b),
    .run  (run)
  );

  // Dropping the run and its terminator leaves exp then frac at the top of rest;
  // a run that reaches bit 0 shifts everything out, giving exp=0 and frac=0.
  always_comb begin
    regime_v = lzd_b ? (run - RW'(1)) : (RW'(0) - run);
    rest     = body << (run + RW'(1));
    frac_v   = {rest, 1'b0} << ES;
  end

  if (ES > 0) begin : g_exp
    assign exp_v = rest[BITS-2 -: EW];
  end else begin : g_noexp
    assign exp_v = '0;
  end

  assign special = s1_q.zero | s1_q.nar;

  always_comb begin
    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
    sign_d      = sign_q;
    zero_d      = zero_q;
    nar_d       = nar_q;
    regime_d    = regime_q;
    exp_d       = exp_q;
    frac_d      = frac_q;
    if (s2_adv && s1_valid_q) begin
      sign_d   = s1_q.sign & ~special;
      zero_d   = s1_q.zero;
      nar_d    = s1_q.nar;
      regime_d = special ? '0 : regime_v;
      exp_d    = special ? '0 : exp_v;
      frac_d   = special ? '0 : frac_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      nar_q       <= 1'b0;
      regime_q    <= '0;
      exp_q       <= '0;
      frac_q      <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      sign_q      <= sign_d;
      zero_q      <= zero_d;
      nar_q       <= nar_d;
      regime_q    <= regime_d;
      exp_q       <= exp_d;
      frac_q      <= frac_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sign   = sign_q;
  assign out_zero   = zero_q;
  assign out_nar    = nar_q;
  assign out_regime = regime_q;
  assign out_exp    = exp_q;
  assign out_frac   = frac_q;

`ifdef POSIT_UNPACK_SCALE_EN
  logic signed [RW+ES-1:0] scale_q, scale_d, scale_v;

  always_comb begin
    scale_v = ((RW+ES)'(regime_v) <<< ES) + (RW+ES)'(exp_v);
    scale_d = scale_q;
    if (s2_adv && s1_valid_q) scale_d = special ? '0 : scale_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scale_q <= '0;
    else        scale_q <= scale_d;
  end

  assign out_scale = scale_q;
`endif

endmodule

// File: tb/tb_posit_unpack_pipe.sv
// Randomised scoreboard bench for posit_unpack_pipe at BITS=8, ES=1.
module tb_posit_unpack_pipe;

  logic       clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data;
  logic       out_sign, out_zero, out_nar;
  logic signed [3:0] out_regime;
  logic [0:0] out_exp;
  logic [7:0] out_frac;
`ifdef POSIT_UNPACK_SCALE_EN
  logic signed [4:0] out_scale;
`endif

  posit_unpack_pipe #(.BITS(8), .ES(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_zero   (out_zero),
    .out_nar    (out_nar),
    .out_regime (out_regime),
    .out_exp    (out_exp),
    .out_frac   (out_frac)
`ifdef POSIT_UNPACK_SCALE_EN
    ,
    .out_scale  (out_scale)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       sign;
    bit       zero;
    bit       nar;
    bit [7:0] mag;
    int       regime;
    int       exp;
    bit [7:0] frac;
    int       scale;
  } exp_t;

  int errors = 0;
  int checks = 0;
  int out_count = 0;
  bit [7:0] sb[$];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reads the posit as a bit string: sign, run, terminator, ES exp bits, fraction.
  function automatic exp_t model(input bit [7:0] w);
    exp_t m;
    int   i, run, pos;
    bit   b;
    m = '{default: 0};
    if (w == 8'h00) begin m.zero = 1; return m; end
    if (w == 8'h80) begin m.nar = 1; return m; end
    m.sign = w[7];
    m.mag  = m.sign ? 8'(256 - int'(w)) : w;
    b = m.mag[6];
    run = 0;
    i = 6;
    while (i >= 0 && m.mag[i] == b) begin run++; i--; end
    m.regime = b ? run - 1 : -run;
    i--;
    for (int k = 0; k < 1; k++) begin
      m.exp = m.exp * 2 + ((i >= 0) ? int'(m.mag[i]) : 0);
      i--;
    end
    pos = 7;
    while (i >= 0) begin m.frac[pos] = m.mag[i]; pos--; i--; end
    m.scale = m.regime * 2 + m.exp;
    return m;
  endfunction

  bit       prev_stall;
  bit [16:0] held;

  function automatic bit [16:0] out_vec();
    return {out_sign, out_zero, out_nar, out_regime, out_exp, out_frac};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid && prev_stall) chk("hold_stable", int'(out_vec() == held), 1);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = model(sb.pop_front());
          out_count++;
          chk("sign",   int'(out_sign), int'(e.sign));
          chk("zero",   int'(out_zero), int'(e.zero));
          chk("nar",    int'(out_nar), int'(e.nar));
          chk("regime", int'(out_regime), e.regime);
          chk("exp",    int'(out_exp), e.exp);
          chk("frac",   int'(out_frac), int'(e.frac));
`ifdef POSIT_UNPACK_SCALE_EN
          chk("scale",  int'(out_scale), e.scale);
`endif
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
      prev_stall = out_valid && !out_ready;
      held       = out_vec();
    end
  end

  task automatic send(input bit [7:0] w);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        done = 1;
      end
    end
    if (!done) begin
      chk("send_timeout", 1, 0);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && !out_valid) done = 1;
    end
    if (!done) chk("drain_timeout", 1, 0);
  endtask

  task automatic directed(input bit [7:0] w);
    chk("dir_in_ready", int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("lat1_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat2_out_valid", int'(out_valid), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t m;
    int   base;
    bit [7:0] r;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_fields", int'(out_vec()), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", int'(in_ready), 1);

    m = model(8'b0101_0110);
    chk("pin1_regime", m.regime, 0);
    chk("pin1_exp", m.exp, 1);
    chk("pin1_frac", int'(m.frac), 8'h60);
    chk("pin1_scale", m.scale, 1);
    m = model(8'b1111_0101);
    chk("pin2_mag", int'(m.mag), 8'h0B);
    chk("pin2_regime", m.regime, -3);
    chk("pin2_frac", int'(m.frac), 8'hC0);
    m = model(8'b0111_1111);
    chk("pin3_regime", m.regime, 6);
    chk("pin3_frac", int'(m.frac), 0);
    m = model(8'h80);
    chk("pin4_nar", int'(m.nar), 1);

    directed(8'b0101_0110);
    directed(8'b1111_0101);
    directed(8'h00);
    directed(8'h80);
    directed(8'b0111_1111);
    drain();

    out_ready = 1'b0;
    base = out_count;
    send(8'h35);
    send(8'hC7);
    chk("stall_in_ready", int'(in_ready), 0);
    fork
      send(8'h5A);
      begin repeat (3) @(posedge clk); #1 out_ready = 1'b1; end
    join
    drain();
    chk("stall_count", out_count - base, 3);

    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h21;
    @(posedge clk); #1 in_data = 8'h6E;
    @(posedge clk); #1 in_valid = 1'b0;
    chk("inflight_out_valid", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", int'(out_valid), 0);
    chk("async_rst_fields", int'(out_vec()), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    chk("rerst_in_ready", int'(in_ready), 1);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      chk("no_stale_output", int'(out_valid), 0);
    end

    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 9))
        0:       r = 8'h00;
        1:       r = 8'h80;
        2:       r = 8'h7F;
        3:       r = 8'h81;
        4:       r = 8'h01;
        default: r = 8'($urandom);
      endcase
      in_data   = r;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("sb_empty_at_end", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
